seven_seg_scan_controller: RTL

//  Drives the 4-digit multiplexed 7-segment display with the Game of Life iteration count.

---
 rtl/seg7_pkg.sv | 13 +
 rtl/seven_seg_scan_controller_bin2bcd.sv | 40 ++++
 rtl/seven_seg_scan_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: FSM states and segment constants shared by the 7-segment scan controller.
package seg7_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF = 8'hFF;
    // Packed with index 15 first; nibbles 10..15 never occur and decode blank.
    localparam logic [15:0][6:0] SEG_LUT = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction
endpackage

// File: rtl/seven_seg_scan_controller_bin2bcd.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle,
// start loads the operand and done marks the final shift cycle.
module bin2bcd_seq #(
    parameter int WIDTH = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin_in,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);
    localparam int SW = 4*DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    logic [SW-1:0] sr_q, sr_d, adj;
    logic [CW-1:0] cnt_q, cnt_d;
    logic run_q, run_d;
    assign done = run_q && cnt_q == CW'(WIDTH - 1);
    assign bcd = sr_q[SW-1 -: 4*DIGITS];
    always_comb begin
        adj = sr_q;
        for (int d = 0; d < DIGITS; d++)
            adj[WIDTH+4*d +: 4] = (sr_q[WIDTH+4*d +: 4] >= 4'd5) ? sr_q[WIDTH+4*d +: 4] + 4'd3 : sr_q[WIDTH+4*d +: 4];
        sr_d = start ? {{(4*DIGITS){1'b0}}, bin_in} : run_q ? adj << 1 : sr_q;
        cnt_d = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
        run_d = start || (run_q && !done);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q <= sr_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: converts a binary count to BCD and scans it onto a multiplexed
// active-low 7-segment display; LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scan_controller
    import seg7_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int DIGITS = 4,
    parameter int REFRESH_DIV = 5000,
    parameter int MAX_SHOW = 9999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value_in,
    input  logic              value_valid,
    output logic              busy,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);
    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    state_t state_q, state_d;
    logic pend_q, pend_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d, clamped, bin;
    logic [4*DIGITS-1:0] disp_q, disp_d, bcd;
    logic [DIGITS-1:0] blank_q, blank_d, blank_new;
    logic [TW-1:0] tick_q, tick_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic start, done, term;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
    logic [DIGITS:1] zero_above;
    always_comb begin
        zero_above = '0;
        zero_above[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--)
            zero_above[i] = zero_above[i+1] && bcd[4*i +: 4] == 4'd0;
        blank_new = {zero_above[DIGITS-1:1], 1'b0};
    end
`else
    localparam logic [DIGITS-1:0] BLANK_RST = '0;
    assign blank_new = '0;
`endif
    assign clamped = (value_in > WIDTH'(MAX_SHOW)) ? WIDTH'(MAX_SHOW) : value_in;
    assign busy = state_q != IDLE;
    assign an = an_q;
    assign seg = seg_q;
    assign dp = 1'b1;
    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bin2bcd (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin), .done(done), .bcd(bcd)
    );
    // A newer strobe supersedes the finished result, so COMMIT only publishes when nothing is waiting.
    always_comb begin
        state_d = state_q;
        pend_d = pend_q;
        pend_val_d = pend_val_q;
        disp_d = disp_q;
        blank_d = blank_q;
        start = 1'b0;
        bin = clamped;
        case (state_q)
            IDLE: begin
                start = value_valid;
                state_d = value_valid ? CONVERT : IDLE;
            end
            CONVERT: begin
                pend_d = pend_q || value_valid;
                pend_val_d = value_valid ? clamped : pend_val_q;
                state_d = done ? COMMIT : CONVERT;
            end
            COMMIT: begin
                start = pend_q || value_valid;
                bin = value_valid ? clamped : pend_val_q;
                pend_d = 1'b0;
                state_d = start ? CONVERT : IDLE;
                disp_d = start ? disp_q : bcd;
                blank_d = start ? blank_q : blank_new;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        term = tick_q == TW'(REFRESH_DIV - 1);
        tick_d = term ? '0 : tick_q + 1'b1;
        idx_d = term ? ((idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1) : idx_q;
        an_d = ~(DIGITS'(1) << idx_d);
        seg_d = blank_q[idx_d] ? SEG_BLANK : seg_decode(disp_q[4*idx_d +: 4]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q <= 1'b0;
            pend_val_q <= '0;
            disp_q <= '0;
            blank_q <= BLANK_RST;
            tick_q <= '0;
            idx_q <= '0;
            an_q <= AN_OFF[DIGITS-1:0];
            seg_q <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            pend_val_q <= pend_val_d;
            disp_q <= disp_d;
            blank_q <= blank_d;
            tick_q <= tick_d;
            idx_q <= idx_d;
            an_q <= an_d;
            seg_q <= seg_d;
        end
    end
endmodule
